operand_fetch_unit: RTL and testbench
=====================================

# operand_fetch_unit

Initiator-side controller for the processor's 32-entry register file. Accepts decoded instructions over a valid/ready handshake and issues the synchronous register-file reads. Covers the register file's one-cycle read latency, forwards in-flight writebacks that the register file would return stale, and presents both source operands to execute over a second valid/ready handshake. It also drives the register file's write port from the writeback stage.

## Interface
- XLEN, 32, data width
- REG_ADDR_W, 5, register index width
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- dec_valid  in  1  decoded instruction available
- dec_ready  out  1  unit accepts instruction this cycle
- dec_rs1, dec_rs2, dec_rd  in  REG_ADDR_W  source/destination indices
- dec_pc  in  XLEN  tag carried through to op_pc
- wb_valid  in  1  writeback this cycle
- wb_rd  in  REG_ADDR_W  writeback destination
- wb_data  in  XLEN  writeback value
- rf_r_en  out  1  register-file read enable
- rf_r1, rf_r2  out  REG_ADDR_W  register-file read indices
- rf_w_en  out  1  register-file write enable
- rf_rd  out  REG_ADDR_W  register-file write index
- rf_write_data  out  XLEN  register-file write data
- rf_r1_read, rf_r2_read  in  XLEN  register-file read data, valid the cycle after rf_r_en
- op_valid  out  1  operands valid
- op_ready  in  1  execute accepts operands
- op_a, op_b  out  XLEN  source operands
- op_rd  out  REG_ADDR_W  destination index
- op_pc  out  XLEN  instruction tag

## Operation
- States: IDLE, FETCH, HOLD.
- dec_ready = rst_n && (IDLE || (HOLD && op_ready)).
- Issue occurs when dec_valid && dec_ready.
  - rf_r_en = 1 combinationally in the issue cycle.
  - rf_r1 = dec_rs1 and rf_r2 = dec_rs2 at all times.
  - rs1, rs2, rd and pc are latched.
- Issue-cycle bypass:
  - If wb_valid, wb_rd != 0 and wb_rd == dec_rs1, latch byp_a = 1 and byp_a_data = wb_data. Otherwise byp_a = 0.
  - byp_b follows the same rule for dec_rs2.
  - Next state is FETCH.
- FETCH lasts exactly one cycle. Operands are captured into registers with this priority, shown for A (B is symmetric):
  1. rs1 == 0 gives 0.
  2. A matching writeback in this cycle gives wb_data.
  3. byp_a gives byp_a_data.
  4. Otherwise rf_r1_read.
  - Next state is HOLD.
- HOLD: op_valid = 1.
  - While waiting, any matching writeback to a nonzero rs1/rs2 overwrites the held op_a/op_b.
  - If op_ready is high and there is a new issue, next state is FETCH.
  - If op_ready is high and there is no issue, next state is IDLE.
  - If op_ready is low, stay in HOLD.
- Write path is a combinational pass-through: rf_w_en = wb_valid, rf_rd = wb_rd, rf_write_data = wb_data.
  - Writes to x0 are passed through; the register file discards them.
  - x0 never forwards.
- One writeback per cycle. Simultaneous writeback and issue are handled by the bypass rules above.

## Timing
- Reset values: state IDLE, op_valid 0, op_a/op_b/op_pc 0, op_rd 0, byp flags and data 0.
  - rf_r_en = 0 and dec_ready = 0 while rst_n is low.
- Issue at cycle N: FETCH at N+1, op_valid from N+2.
- Sustained throughput is one instruction per 2 cycles, because issue is allowed in the HOLD-accept cycle.
- op_a, op_b, op_rd and op_pc are register outputs. They change only on capture, on forwarding update in HOLD, or on reset.
- When op_valid is 1 and op_ready is 0, op_rd and op_pc are stable.
- Reset asserted in FETCH or HOLD drops the instruction. op_valid goes to 0 immediately (asynchronous).

## Structure
- Shared package `rv_core_pkg` holds XLEN, REG_ADDR_W and the `ofu_state_t` enum (IDLE, FETCH, HOLD).
- Sub-module `operand_bypass` implements the 4-way priority select for one operand. Inputs: index, wb fields, bypass flag and data, rf data. It is instantiated twice, for A and B.

## Test plan
- Register file initialised with x5 = 1, x7 = 1. Issue rs1 = 5, rs2 = 7 at cycle 0 -> op_valid at cycle 2 with op_a = 1, op_b = 1.
- Issue rs1 = 0 with a same-cycle writeback of x0 = 0xDEADBEEF -> op_a = 0, and the register file's x0 is unchanged.
- Issue rs1 = 3 with a same-cycle writeback of x3 = 0x1234 -> op_a = 0x1234, even though the register file returns the old value.
- Issue rs2 = 4, then writeback x4 = 0xAA during FETCH -> op_b = 0xAA.
- Hold op_ready low for 3 cycles in HOLD with rs1 = 5 and write back x5 = 0x55 in the 2nd cycle -> op_a becomes 0x55, op_b is unchanged, dec_ready = 0 throughout.
- Continuous back-to-back issue with op_ready = 1 -> an accept every 2 cycles. Assert rst_n low during FETCH -> op_valid is 0 and no operand is delivered for that instruction.

Source files
------------

// File: rtl/rv_core_pkg.sv
// Shared core definitions: datapath widths, operand-fetch states,
// and the writeback-forwarding match used by both operand paths.
package rv_core_pkg;

  localparam int XLEN       = 32;
  localparam int REG_ADDR_W = 5;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2
  } ofu_state_t;

  // x0 is hardwired, so a write to it must never be forwarded
  function automatic logic fwd_hit(
    input logic                  v,
    input logic [REG_ADDR_W-1:0] wb_rd,
    input logic [REG_ADDR_W-1:0] idx
  );
    return v && (wb_rd != '0) && (wb_rd == idx);
  endfunction

endpackage

// File: rtl/operand_bypass.sv
// Four-way operand source select for one source register:
// x0, live writeback, issue-cycle bypass, then register-file data.
module operand_bypass
  import rv_core_pkg::*;
(
  input  logic [REG_ADDR_W-1:0] i_idx,
  input  logic                  i_wb_valid,
  input  logic [REG_ADDR_W-1:0] i_wb_rd,
  input  logic [XLEN-1:0]       i_wb_data,
  input  logic                  i_byp,
  input  logic [XLEN-1:0]       i_byp_data,
  input  logic [XLEN-1:0]       i_rf_data,
  output logic [XLEN-1:0]       o_data
);

  logic w_zero;
  logic w_hit;
  logic w_byp;

  assign w_zero = (i_idx == '0);
  assign w_hit  = fwd_hit(i_wb_valid, i_wb_rd, i_idx);
  assign w_byp  = i_byp && !w_zero && !w_hit;

  always_comb begin
    o_data = i_rf_data;
    unique case (1'b1)
      w_zero:  o_data = '0;
      w_hit:   o_data = i_wb_data;
      w_byp:   o_data = i_byp_data;
      default: o_data = i_rf_data;
    endcase
  end

endmodule

// File: rtl/operand_fetch_unit.sv
// Register-file read initiator: issues reads, covers the one-cycle
// read latency, forwards writebacks and holds operands for execute.
module operand_fetch_unit
  import rv_core_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  dec_valid,
  output logic                  dec_ready,
  input  logic [REG_ADDR_W-1:0] dec_rs1,
  input  logic [REG_ADDR_W-1:0] dec_rs2,
  input  logic [REG_ADDR_W-1:0] dec_rd,
  input  logic [XLEN-1:0]       dec_pc,
  input  logic                  wb_valid,
  input  logic [REG_ADDR_W-1:0] wb_rd,
  input  logic [XLEN-1:0]       wb_data,
  output logic                  rf_r_en,
  output logic [REG_ADDR_W-1:0] rf_r1,
  output logic [REG_ADDR_W-1:0] rf_r2,
  output logic                  rf_w_en,
  output logic [REG_ADDR_W-1:0] rf_rd,
  output logic [XLEN-1:0]       rf_write_data,
  input  logic [XLEN-1:0]       rf_r1_read,
  input  logic [XLEN-1:0]       rf_r2_read,
  output logic                  op_valid,
  input  logic                  op_ready,
  output logic [XLEN-1:0]       op_a,
  output logic [XLEN-1:0]       op_b,
  output logic [REG_ADDR_W-1:0] op_rd,
  output logic [XLEN-1:0]       op_pc
);

  ofu_state_t r_state;
  ofu_state_t w_next;

  logic [REG_ADDR_W-1:0] r_rs1;
  logic [REG_ADDR_W-1:0] r_rs2;
  logic [REG_ADDR_W-1:0] r_rd;
  logic [XLEN-1:0]       r_pc;
  logic                  r_byp_a;
  logic                  r_byp_b;
  logic [XLEN-1:0]       r_byp_a_data;
  logic [XLEN-1:0]       r_byp_b_data;
  logic [XLEN-1:0]       r_op_a;
  logic [XLEN-1:0]       r_op_b;
  logic [REG_ADDR_W-1:0] r_op_rd;
  logic [XLEN-1:0]       r_op_pc;

  logic            w_issue;
  logic            w_hit_a;
  logic            w_hit_b;
  logic [XLEN-1:0] w_a;
  logic [XLEN-1:0] w_b;

  assign w_issue = dec_valid && dec_ready;
  assign w_hit_a = fwd_hit(wb_valid, wb_rd, r_rs1);
  assign w_hit_b = fwd_hit(wb_valid, wb_rd, r_rs2);

  assign rf_r1         = dec_rs1;
  assign rf_r2         = dec_rs2;
  assign rf_w_en       = wb_valid;
  assign rf_rd         = wb_rd;
  assign rf_write_data = wb_data;

  assign op_a  = r_op_a;
  assign op_b  = r_op_b;
  assign op_rd = r_op_rd;
  assign op_pc = r_op_pc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:    if (w_issue) w_next = FETCH;
      FETCH:   w_next = HOLD;
      HOLD:    if (op_ready) w_next = w_issue ? FETCH : IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    dec_ready = rst_n && ((r_state == IDLE) ||
                          ((r_state == HOLD) && op_ready));
    rf_r_en   = dec_valid && dec_ready;
    op_valid  = (r_state == HOLD);
  end

  operand_bypass u_byp_a (
    .i_idx      (r_rs1),
    .i_wb_valid (wb_valid),
    .i_wb_rd    (wb_rd),
    .i_wb_data  (wb_data),
    .i_byp      (r_byp_a),
    .i_byp_data (r_byp_a_data),
    .i_rf_data  (rf_r1_read),
    .o_data     (w_a)
  );

  operand_bypass u_byp_b (
    .i_idx      (r_rs2),
    .i_wb_valid (wb_valid),
    .i_wb_rd    (wb_rd),
    .i_wb_data  (wb_data),
    .i_byp      (r_byp_b),
    .i_byp_data (r_byp_b_data),
    .i_rf_data  (rf_r2_read),
    .o_data     (w_b)
  );

  // A writeback in the issue cycle lands after the RF read samples
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rs1        <= '0;
      r_rs2        <= '0;
      r_rd         <= '0;
      r_pc         <= '0;
      r_byp_a      <= 1'b0;
      r_byp_b      <= 1'b0;
      r_byp_a_data <= '0;
      r_byp_b_data <= '0;
      r_op_a       <= '0;
      r_op_b       <= '0;
      r_op_rd      <= '0;
      r_op_pc      <= '0;
    end else begin
      if (w_issue) begin
        r_rs1        <= dec_rs1;
        r_rs2        <= dec_rs2;
        r_rd         <= dec_rd;
        r_pc         <= dec_pc;
        r_byp_a      <= fwd_hit(wb_valid, wb_rd, dec_rs1);
        r_byp_b      <= fwd_hit(wb_valid, wb_rd, dec_rs2);
        r_byp_a_data <= wb_data;
        r_byp_b_data <= wb_data;
      end
      if (r_state == FETCH) begin
        r_op_a  <= w_a;
        r_op_b  <= w_b;
        r_op_rd <= r_rd;
        r_op_pc <= r_pc;
      end else if (r_state == HOLD) begin
        if (w_hit_a) r_op_a <= wb_data;
        if (w_hit_b) r_op_b <= wb_data;
      end
    end
  end

endmodule

// File: tb/tb_operand_fetch_unit.sv
// Bench for operand_fetch_unit: behavioural register file plus an
// architectural-state model of what a held operand must be.
module tb_operand_fetch_unit;

  logic        clk;
  logic        rst_n;
  logic        dec_valid;
  logic        dec_ready;
  logic [4:0]  dec_rs1, dec_rs2, dec_rd;
  logic [31:0] dec_pc;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        rf_r_en;
  logic [4:0]  rf_r1, rf_r2;
  logic        rf_w_en;
  logic [4:0]  rf_rd;
  logic [31:0] rf_write_data;
  logic [31:0] rf_r1_read, rf_r2_read;
  logic        op_valid;
  logic        op_ready;
  logic [31:0] op_a, op_b;
  logic [4:0]  op_rd;
  logic [31:0] op_pc;

  operand_fetch_unit dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .dec_valid     (dec_valid),
    .dec_ready     (dec_ready),
    .dec_rs1       (dec_rs1),
    .dec_rs2       (dec_rs2),
    .dec_rd        (dec_rd),
    .dec_pc        (dec_pc),
    .wb_valid      (wb_valid),
    .wb_rd         (wb_rd),
    .wb_data       (wb_data),
    .rf_r_en       (rf_r_en),
    .rf_r1         (rf_r1),
    .rf_r2         (rf_r2),
    .rf_w_en       (rf_w_en),
    .rf_rd         (rf_rd),
    .rf_write_data (rf_write_data),
    .rf_r1_read    (rf_r1_read),
    .rf_r2_read    (rf_r2_read),
    .op_valid      (op_valid),
    .op_ready      (op_ready),
    .op_a          (op_a),
    .op_b          (op_b),
    .op_rd         (op_rd),
    .op_pc         (op_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vecs = 0;
  int errs = 0;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Register file: one-cycle read latency, reads see pre-write value
  logic [31:0] mem [32];
  initial begin
    for (int i = 0; i < 32; i++) mem[i] = 32'h0;
    mem[5] = 32'd1;
    mem[7] = 32'd1;
  end
  always @(posedge clk) begin
    if (rf_r_en) begin
      rf_r1_read <= mem[rf_r1];
      rf_r2_read <= mem[rf_r2];
    end
    if (rf_w_en && rf_rd != 5'd0) mem[rf_rd] <= rf_write_data;
  end

  function automatic logic [31:0] arch(input logic [4:0] r);
    return (r == 5'd0) ? 32'h0 : mem[r];
  endfunction

  // A held operand must always equal the current architectural value
  typedef struct {
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [31:0] pc;
  } ins_t;
  ins_t q[$];
  ins_t t;

  always @(negedge clk) begin
    if (!rst_n) begin
      q.delete();
    end else begin
      chk("dec_ready", dec_ready,
          (q.size() == 0) || (op_valid && op_ready));
      chk("wr_pass", {rf_w_en, rf_rd, rf_write_data},
          {wb_valid, wb_rd, wb_data});
      if (op_valid) begin
        if (q.size() == 0) begin
          vecs++; errs++;
          $display("FAIL spurious_op: op_valid with no instruction");
        end else begin
          chk("op_a", op_a, arch(q[0].rs1));
          chk("op_b", op_b, arch(q[0].rs2));
          chk("op_rd", op_rd, q[0].rd);
          chk("op_pc", op_pc, q[0].pc);
          if (op_ready) void'(q.pop_front());
        end
      end
      if (dec_valid && dec_ready) begin
        chk("rf_read", {rf_r_en, rf_r1, rf_r2},
            {1'b1, dec_rs1, dec_rs2});
        t.rs1 = dec_rs1; t.rs2 = dec_rs2;
        t.rd = dec_rd;   t.pc = dec_pc;
        q.push_back(t);
      end
    end
  end

  task automatic issue(input logic [4:0] a, input logic [4:0] b,
                       input logic [4:0] d, input logic [31:0] pc);
    int n = 0;
    dec_valid = 1'b1;
    dec_rs1 = a; dec_rs2 = b; dec_rd = d; dec_pc = pc;
    @(negedge clk);
    while (!dec_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("issue_ready", dec_ready, 1'b1);
    @(posedge clk); #1;
    dec_valid = 1'b0;
  endtask

  task automatic wait_hold();
    int n = 0;
    @(negedge clk);
    while (!op_valid && n < 10) begin
      @(negedge clk);
      n++;
    end
    chk("hold_reach", op_valid, 1'b1);
  endtask

  task automatic accept();
    op_ready = 1'b1;
    @(posedge clk); #1;
    op_ready = 1'b0;
  endtask

  task automatic wb(input logic v, input logic [4:0] r,
                    input logic [31:0] d);
    wb_valid = v; wb_rd = r; wb_data = d;
  endtask

  int acc;

  initial begin
    rst_n = 1'b0;
    dec_valid = 1'b1;
    dec_rs1 = 5'd5; dec_rs2 = 5'd7; dec_rd = 5'd1; dec_pc = 32'h0;
    op_ready = 1'b0;
    wb(1'b0, 5'd0, 32'h0);
    repeat (2) @(negedge clk);
    chk("rst_dec_ready", dec_ready, 1'b0);
    chk("rst_rf_r_en", rf_r_en, 1'b0);
    chk("rst_op_valid", op_valid, 1'b0);
    chk("rst_op_a", op_a, 32'h0);
    chk("rst_op_b", op_b, 32'h0);
    chk("rst_op_rd_pc", {op_rd, op_pc}, 37'h0);
    dec_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // x5, x7 both 1: operands arrive two cycles after issue
    issue(5'd5, 5'd7, 5'd9, 32'h1000);
    @(negedge clk);
    chk("t1_fetch_valid", op_valid, 1'b0);
    @(negedge clk);
    chk("t1_valid", op_valid, 1'b1);
    chk("t1_a", op_a, 32'd1);
    chk("t1_b", op_b, 32'd1);
    chk("t1_pc", op_pc, 32'h1000);
    accept();

    // Writes to x0 pass through but never forward
    wb(1'b1, 5'd0, 32'hDEADBEEF);
    issue(5'd0, 5'd7, 5'd2, 32'h1004);
    wb(1'b0, 5'd0, 32'h0);
    wait_hold();
    chk("t2_a_x0", op_a, 32'h0);
    chk("t2_x0_kept", arch(5'd0), 32'h0);
    accept();

    wb(1'b1, 5'd3, 32'h1234);
    issue(5'd3, 5'd0, 5'd3, 32'h1008);
    wb(1'b0, 5'd0, 32'h0);
    wait_hold();
    chk("t3_a_issue_byp", op_a, 32'h1234);
    accept();

    issue(5'd0, 5'd4, 5'd4, 32'h100C);
    wb(1'b1, 5'd4, 32'hAA);
    @(posedge clk); #1;
    wb(1'b0, 5'd0, 32'h0);
    wait_hold();
    chk("t4_b_fetch_fwd", op_b, 32'hAA);
    accept();

    // Stall three cycles, x5 rewritten mid-stall
    issue(5'd5, 5'd7, 5'd6, 32'h1010);
    wait_hold();
    chk("t5_c1_ready", dec_ready, 1'b0);
    chk("t5_c1_a", op_a, 32'd1);
    @(posedge clk); #1;
    wb(1'b1, 5'd5, 32'h55);
    @(negedge clk);
    chk("t5_c2_ready", dec_ready, 1'b0);
    @(posedge clk); #1;
    wb(1'b0, 5'd0, 32'h0);
    @(negedge clk);
    chk("t5_c3_ready", dec_ready, 1'b0);
    chk("t5_a", op_a, 32'h55);
    chk("t5_b", op_b, 32'd1);
    chk("t5_rd_pc", {op_rd, op_pc}, {5'd6, 32'h1010});
    accept();

    // Back-to-back: issue at cycle 0, accepts at 2,4,...,18
    op_ready = 1'b1;
    dec_valid = 1'b1;
    acc = 0;
    for (int i = 0; i < 20; i++) begin
      dec_rs1 = 5'(i % 8);
      dec_rs2 = 5'((i + 3) % 8);
      dec_rd = 5'(i);
      dec_pc = 32'h2000 + 32'(4 * i);
      wb(i[0], 5'((i + 1) % 8), 32'h11 * 32'(i + 1));
      @(negedge clk);
      if (op_valid && op_ready) acc++;
      @(posedge clk); #1;
    end
    dec_valid = 1'b0;
    wb(1'b0, 5'd0, 32'h0);
    chk("b2b_accepts", 32'(acc), 32'd9);
    repeat (3) @(posedge clk);
    #1;

    // Reset during FETCH drops the instruction
    op_ready = 1'b0;
    issue(5'd1, 5'd2, 5'd3, 32'h3000);
    #2;
    rst_n = 1'b0;
    dec_valid = 1'b1;
    #1;
    chk("rst_async_valid", op_valid, 1'b0);
    @(negedge clk);
    chk("rst_f_valid", op_valid, 1'b0);
    chk("rst_f_ready", dec_ready, 1'b0);
    chk("rst_f_r_en", rf_r_en, 1'b0);
    chk("rst_f_op_a", op_a, 32'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    dec_valid = 1'b0;
    op_ready = 1'b1;
    acc = 0;
    repeat (4) begin
      @(negedge clk);
      if (op_valid) acc++;
    end
    chk("rst_dropped", 32'(acc), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
